// File: rtl/mmcm_drp_pkg.sv
// Shared types and constants for the MMCM DRP reconfiguration master.
package mmcm_drp_pkg;

   localparam int DRP_ADDR_W       = 7;
   localparam int DRP_DATA_W       = 16;
   localparam int DEF_RST_HOLD     = 4;
   localparam int DEF_DRDY_TIMEOUT = 64;
   localparam int DEF_LOCK_TIMEOUT = 65536;

   typedef enum logic [3:0] {
      IDLE,
      ASSERT_RST,
      WAIT_CFG,
      RD_REQ,
      RD_WAIT,
      WR_REQ,
      WR_WAIT,
      RELEASE,
      WAIT_LOCK,
      FINISH,
      ERR
   } state_t;

   // One extra bit beyond the largest count so the terminal compare never wraps.
   function automatic int timeout_cnt_w(input int max_cycles);
      return $clog2(max_cycles) + 1;
   endfunction

endpackage

// File: rtl/mmcm_drp_if.sv
// DRP bus and configuration-entry stream bundles used by the reconfiguration master.
interface mmcm_drp_if
   import mmcm_drp_pkg::*;
#(
   parameter int ADDR_W = DRP_ADDR_W,
   parameter int DATA_W = DRP_DATA_W
) ();
   logic [ADDR_W-1:0] drp_daddr;
   logic [DATA_W-1:0] drp_di;
   logic              drp_den;
   logic              drp_dwe;
   logic [DATA_W-1:0] drp_do;
   logic              drp_drdy;

   modport master (output drp_daddr, drp_di, drp_den, drp_dwe, input drp_do, drp_drdy);
   modport slave  (input drp_daddr, drp_di, drp_den, drp_dwe, output drp_do, drp_drdy);
endinterface

interface mmcm_cfg_if
   import mmcm_drp_pkg::*;
#(
   parameter int ADDR_W = DRP_ADDR_W,
   parameter int DATA_W = DRP_DATA_W
) ();
   logic              cfg_valid;
   logic              cfg_ready;
   logic [ADDR_W-1:0] cfg_addr;
   logic [DATA_W-1:0] cfg_mask;
   logic [DATA_W-1:0] cfg_data;
   logic              cfg_last;

   modport master (output cfg_valid, cfg_addr, cfg_mask, cfg_data, cfg_last, input cfg_ready);
   modport slave  (input cfg_valid, cfg_addr, cfg_mask, cfg_data, cfg_last, output cfg_ready);
endinterface

// File: rtl/mmcm_drp_reconfig_sync_2ff.sv
// Two-flop synchronizer for bringing the asynchronous MMCM LOCKED pin into the clk domain.
module sync_2ff (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/mmcm_drp_reconfig.sv
// MMCM DRP reconfiguration master: holds the MMCM in reset, applies read-modify-write
// register updates over DRP, then releases reset and waits for a synchronized lock.
module mmcm_drp_reconfig
   import mmcm_drp_pkg::*;
#(
   parameter int ADDR_W       = DRP_ADDR_W,
   parameter int DATA_W       = DRP_DATA_W,
   parameter int RST_HOLD     = DEF_RST_HOLD,
   parameter int DRDY_TIMEOUT = DEF_DRDY_TIMEOUT,
   parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   output logic       busy,
   output logic       done,
   output logic       error,
   mmcm_cfg_if.slave  cfg,
   mmcm_drp_if.master drp,
   output logic       mmcm_rst,
   input  logic       mmcm_locked
);

   localparam int CNT_MAX_A = (LOCK_TIMEOUT > DRDY_TIMEOUT) ? LOCK_TIMEOUT : DRDY_TIMEOUT;
   localparam int CNT_MAX   = (CNT_MAX_A > RST_HOLD) ? CNT_MAX_A : RST_HOLD;
   localparam int CNT_W     = timeout_cnt_w(CNT_MAX);

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] mask_q, data_q, rmw_value;
   logic              last_q;
   logic              lock_sync;

   sync_2ff u_lock_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (mmcm_locked),
      .q       (lock_sync)
   );

   assign rmw_value = (drp.drp_do & mask_q) | (data_q & ~mask_q);

   // Each wait state exits on its event or once its cycle budget is spent; the
   // counter restarts from zero on every state change.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:       if (start) state_nxt = ASSERT_RST;
         ASSERT_RST: if (cnt == CNT_W'(RST_HOLD - 1)) state_nxt = WAIT_CFG;
         WAIT_CFG:   if (cfg.cfg_valid) state_nxt = RD_REQ;
         RD_REQ:     state_nxt = RD_WAIT;
         RD_WAIT: begin
            if (drp.drp_drdy)                          state_nxt = WR_REQ;
            else if (cnt == CNT_W'(DRDY_TIMEOUT - 1))  state_nxt = ERR;
         end
         WR_REQ:     state_nxt = WR_WAIT;
         WR_WAIT: begin
            if (drp.drp_drdy)                          state_nxt = last_q ? RELEASE : WAIT_CFG;
            else if (cnt == CNT_W'(DRDY_TIMEOUT - 1))  state_nxt = ERR;
         end
         RELEASE:    state_nxt = WAIT_LOCK;
         WAIT_LOCK: begin
            if (lock_sync)                             state_nxt = FINISH;
            else if (cnt == CNT_W'(LOCK_TIMEOUT - 1))  state_nxt = ERR;
         end
         FINISH:     state_nxt = IDLE;
         ERR:        state_nxt = IDLE;
         default:    state_nxt = IDLE;
      endcase
   end

   assign busy          = !(state inside {IDLE, FINISH, ERR});
   assign done          = state inside {FINISH, ERR};
   assign mmcm_rst      = state inside {ASSERT_RST, WAIT_CFG, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT};
   assign cfg.cfg_ready = (state == WAIT_CFG);
   assign drp.drp_den   = state inside {RD_REQ, WR_REQ};

   // State, shared timeout counter, latched entry and the held DRP address/data/write-enable.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         cnt           <= '0;
         error         <= 1'b0;
         mask_q        <= '0;
         data_q        <= '0;
         last_q        <= 1'b0;
         drp.drp_daddr <= '0;
         drp.drp_di    <= '0;
         drp.drp_dwe   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state_nxt != state) cnt <= '0;
         else                    cnt <= cnt + CNT_W'(1);

         if (state == IDLE && start) error <= 1'b0;
         if (state_nxt == ERR)       error <= 1'b1;

         if (state == WAIT_CFG && cfg.cfg_valid) begin
            drp.drp_daddr <= cfg.cfg_addr;
            mask_q        <= cfg.cfg_mask;
            data_q        <= cfg.cfg_data;
            last_q        <= cfg.cfg_last;
         end

         if (state_nxt == RD_REQ) drp.drp_dwe <= 1'b0;
         if (state_nxt == WR_REQ) begin
            drp.drp_dwe <= 1'b1;
            drp.drp_di  <= rmw_value;
         end
      end
   end

endmodule

// File: tb/tb_mmcm_drp_reconfig.sv
// Directed bench for mmcm_drp_reconfig with a DRP slave model, an MMCM lock model
// and an in-order scoreboard of expected DRP transactions.
module tb_mmcm_drp_reconfig;
   import mmcm_drp_pkg::*;

   typedef struct {
      logic        we;
      logic [6:0]  addr;
      logic [15:0] data;
   } drp_txn_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic start = 1'b0;
   logic busy, done, error, mmcm_rst;
   logic mmcm_locked = 1'b0;

   mmcm_cfg_if cfg_bus ();
   mmcm_drp_if drp_bus ();

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   drp_txn_t sb[$];
   int drdy_cnt = 0;
   int drdy_delay = 3;
   int den_cyc = 0;
   int drdy_cyc = 0;
   int n_rd = 0;
   int n_wr = 0;
   int lock_cnt = 0;
   bit drdy_never = 1'b0;
   bit lock_enable = 1'b1;
   logic model_drdy = 1'b0;
   logic stray_drdy = 1'b0;
   logic [6:0] cur_addr = '0;

   mmcm_drp_reconfig dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .busy        (busy),
      .done        (done),
      .error       (error),
      .cfg         (cfg_bus),
      .drp         (drp_bus),
      .mmcm_rst    (mmcm_rst),
      .mmcm_locked (mmcm_locked)
   );

   assign drp_bus.drp_drdy = model_drdy | stray_drdy;

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   function automatic logic [15:0] romValue(input logic [6:0] a);
      case (a)
         7'h08:   return 16'hFFFF;
         7'h09:   return 16'hA5A5;
         7'h14:   return 16'h0000;
         7'h0B:   return 16'h1234;
         7'h0C:   return 16'h8000;
         7'h0D:   return 16'h0F0F;
         7'h0E:   return 16'h7700;
         default: return 16'hC3C3;
      endcase
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // DRP slave: answers each DEN with DRDY a fixed number of cycles later and
   // checks every request against the head of the scoreboard.
   always @(negedge clk) begin
      drp_txn_t exp_t;
      model_drdy = 1'b0;
      if (drdy_cnt > 0) begin
         drdy_cnt--;
         if (drdy_cnt == 0) begin
            model_drdy     = 1'b1;
            drp_bus.drp_do = romValue(cur_addr);
            drdy_cyc       = cyc;
         end
      end
      if (drp_bus.drp_den === 1'b1) begin
         den_cyc  = cyc;
         cur_addr = drp_bus.drp_daddr;
         checkOutput("rst_held_at_den", mmcm_rst, 1);
         checkOutput("drp_txn_expected", sb.size() > 0, 1);
         if (sb.size() > 0) begin
            exp_t = sb.pop_front();
            checkOutput("drp_dwe", drp_bus.drp_dwe, exp_t.we);
            checkOutput("drp_daddr", drp_bus.drp_daddr, exp_t.addr);
            if (exp_t.we) checkOutput("drp_di", drp_bus.drp_di, exp_t.data);
         end
         if (drp_bus.drp_dwe === 1'b1) n_wr++;
         else                          n_rd++;
         if (!drdy_never) drdy_cnt = drdy_delay;
      end
   end

   // MMCM lock model: locks a few cycles after RST is released, unless disabled.
   always @(negedge clk) begin
      if (mmcm_rst !== 1'b0 || !lock_enable) begin
         lock_cnt    = 0;
         mmcm_locked = 1'b0;
      end else if (lock_cnt < 5) begin
         lock_cnt++;
      end else begin
         mmcm_locked = 1'b1;
      end
   end

   task automatic pulseStart();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic waitReady(input string tag);
      int t = 0;
      while (cfg_bus.cfg_ready !== 1'b1 && t < 200) begin
         @(negedge clk);
         t++;
      end
      checkOutput(tag, cfg_bus.cfg_ready, 1);
   endtask

   task automatic applyStimulus(input logic [6:0] a, input logic [15:0] m, input logic [15:0] d,
                                input logic l, input logic [15:0] exp_wr);
      sb.push_back('{1'b0, a, 16'h0000});
      sb.push_back('{1'b1, a, exp_wr});
      @(negedge clk);
      cfg_bus.cfg_valid = 1'b1;
      cfg_bus.cfg_addr  = a;
      cfg_bus.cfg_mask  = m;
      cfg_bus.cfg_data  = d;
      cfg_bus.cfg_last  = l;
      waitReady("cfg_handshake");
      @(negedge clk);
      cfg_bus.cfg_valid = 1'b0;
      cfg_bus.cfg_last  = 1'b0;
   endtask

   task automatic waitDone(input int limit, output int at);
      int t = 0;
      while (done !== 1'b1 && t < limit) begin
         @(negedge clk);
         t++;
      end
      checkOutput("done_pulse", done, 1);
      at = cyc;
   endtask

   task automatic checkResetValues();
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_error", error, 0);
      checkOutput("rst_cfg_ready", cfg_bus.cfg_ready, 0);
      checkOutput("rst_drp_den", drp_bus.drp_den, 0);
      checkOutput("rst_drp_dwe", drp_bus.drp_dwe, 0);
      checkOutput("rst_mmcm_rst", mmcm_rst, 0);
      checkOutput("rst_drp_daddr", drp_bus.drp_daddr, 0);
      checkOutput("rst_drp_di", drp_bus.drp_di, 0);
   endtask

   initial begin
      int t;
      int done_at;
      int rd0;
      int wr0;

      cfg_bus.cfg_valid = 1'b0;
      cfg_bus.cfg_addr  = '0;
      cfg_bus.cfg_mask  = '0;
      cfg_bus.cfg_data  = '0;
      cfg_bus.cfg_last  = 1'b0;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      checkResetValues();
      reset_n = 1'b1;

      $display("[TB] single entry read-modify-write");
      pulseStart();
      checkOutput("busy_after_start", busy, 1);
      checkOutput("rst_after_start", mmcm_rst, 1);
      t = 1;
      while (cfg_bus.cfg_ready !== 1'b1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      checkOutput("cfg_ready_latency", t, DEF_RST_HOLD + 1);
      applyStimulus(7'h08, 16'h1000, 16'h0041, 1'b1, 16'h1041);
      waitDone(500, done_at);
      checkOutput("t1_error", error, 0);
      checkOutput("t1_rst_released", mmcm_rst, 0);
      checkOutput("t1_busy_at_done", busy, 0);
      @(negedge clk);
      checkOutput("t1_done_one_cycle", done, 0);
      checkOutput("t1_sb_empty", sb.size(), 0);

      $display("[TB] three entries");
      rd0 = n_rd;
      wr0 = n_wr;
      pulseStart();
      applyStimulus(7'h08, 16'hFF00, 16'h00AB, 1'b0, 16'hFFAB);
      applyStimulus(7'h09, 16'h0F0F, 16'h3030, 1'b0, 16'h3535);
      applyStimulus(7'h14, 16'hFFFF, 16'hBEEF, 1'b1, 16'h0000);
      t = 0;
      while (mmcm_rst !== 1'b0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      checkOutput("t2_rst_released", mmcm_rst, 0);
      checkOutput("t2_release_after_last_drdy", cyc - drdy_cyc, 1);
      checkOutput("t2_reads", n_rd - rd0, 3);
      checkOutput("t2_writes", n_wr - wr0, 3);
      checkOutput("t2_sb_empty", sb.size(), 0);
      waitDone(500, done_at);
      checkOutput("t2_error", error, 0);

      $display("[TB] DRDY timeout");
      drdy_never = 1'b1;
      pulseStart();
      applyStimulus(7'h0A, 16'h00FF, 16'h1200, 1'b1, 16'h12C3);
      waitDone(500, done_at);
      checkOutput("t3_timeout_latency", done_at - den_cyc, DEF_DRDY_TIMEOUT + 1);
      checkOutput("t3_error_set", error, 1);
      checkOutput("t3_rst_released", mmcm_rst, 0);
      checkOutput("t3_no_write_issued", sb.size(), 1);
      sb.delete();
      drdy_never = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("t3_error_level_held", error, 1);

      $display("[TB] restart clears error, stray start and DRDY ignored");
      pulseStart();
      checkOutput("t3_error_cleared", error, 0);
      waitReady("t5_ready");
      stray_drdy = 1'b1;
      start      = 1'b1;
      @(negedge clk);
      stray_drdy = 1'b0;
      start      = 1'b0;
      @(negedge clk);
      checkOutput("t5_still_wait_cfg", cfg_bus.cfg_ready, 1);
      checkOutput("t5_no_den", drp_bus.drp_den, 0);
      checkOutput("t5_busy", busy, 1);
      applyStimulus(7'h0B, 16'h0000, 16'h5A5A, 1'b1, 16'h5A5A);
      waitDone(500, done_at);
      checkOutput("t5_error", error, 0);
      repeat (3) @(negedge clk);
      checkOutput("t5_idle_after", busy, 0);

      $display("[TB] lock timeout");
      lock_enable = 1'b0;
      pulseStart();
      applyStimulus(7'h0C, 16'hF000, 16'h0123, 1'b1, 16'h8123);
      waitDone(70000, done_at);
      checkOutput("t4_lock_timeout_latency", done_at - drdy_cyc, DEF_LOCK_TIMEOUT + 2);
      checkOutput("t4_error_set", error, 1);
      checkOutput("t4_rst_released", mmcm_rst, 0);
      lock_enable = 1'b1;

      $display("[TB] reset during write wait");
      pulseStart();
      applyStimulus(7'h0D, 16'h00FF, 16'hAB00, 1'b1, 16'hAB0F);
      t = 0;
      while (!(drp_bus.drp_den === 1'b1 && drp_bus.drp_dwe === 1'b1) && t < 50) begin
         @(negedge clk);
         t++;
      end
      checkOutput("t6_write_issued", drp_bus.drp_den & drp_bus.drp_dwe, 1);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      checkResetValues();
      checkOutput("t6_sb_empty", sb.size(), 0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      pulseStart();
      applyStimulus(7'h0E, 16'hFF00, 16'h00CD, 1'b1, 16'h77CD);
      waitDone(500, done_at);
      checkOutput("t6_error", error, 0);
      checkOutput("t6_rst_released", mmcm_rst, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
